// File: rtl/xor_stream_ctrl.sv
// xor_stream_ctrl: byte-stream XOR cipher with a loadable repeating key.
// A key of KEY_BYTES bytes is written while idle; each message of len bytes
// is then XORed byte-by-byte with the key (restarting at key byte 0) and
// passed downstream through a one-deep registered output stage.
module xor_stream_ctrl #(
    parameter int DATA_W    = 8,
    parameter int KEY_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_wr,
    input  logic [DATA_W-1:0] key_byte,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              key_ready,
    output logic              key_err
);

    localparam int IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] key_reg [KEY_BYTES];
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        remaining;
    logic              accept;
    logic              drain;

    // Key position advance with explicit wrap so non-power-of-two depths stay correct
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_LAST) ? '0 : i + 1'b1;
    endfunction

    // The cipher itself: XOR is its own inverse, so one path serves both directions
    function automatic logic [DATA_W-1:0] apply_key(input logic [DATA_W-1:0] d,
                                                    input logic [DATA_W-1:0] k);
        return d ^ k;
    endfunction

    // Upstream may only advance while running and the output stage can take a byte
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign busy     = (state != IDLE);

    // Key storage: written only while idle, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KEY_BYTES; i++) begin
                key_reg[i] <= '0;
            end
        end else if (state == IDLE && key_wr) begin
            key_reg[wr_ptr] <= key_byte;
        end
    end

    // Control FSM with registered stream output and single-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            idx       <= '0;
            remaining <= '0;
            key_ready <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            key_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_wr) begin
                        wr_ptr <= next_idx(wr_ptr);
                        // Completing the last slot wins when the key is one byte deep
                        if (wr_ptr == IDX_LAST) begin
                            key_ready <= 1'b1;
                        end else if (wr_ptr == '0) begin
                            key_ready <= 1'b0;
                        end
                    end
                    // abort is meaningless here, so start always takes effect
                    if (start) begin
                        if (!key_ready) begin
                            key_err <= 1'b1;
                        end else if (len == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= len;
                            idx       <= '0;
                            state     <= RUN;
                        end
                    end
                end
                RUN, FLUSH: begin
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        remaining <= '0;
                    end else if (state == RUN) begin
                        if (accept) begin
                            out_data  <= apply_key(in_data, key_reg[idx]);
                            out_valid <= 1'b1;
                            idx       <= next_idx(idx);
                            remaining <= remaining - 8'd1;
                            if (remaining == 8'd1) begin
                                state <= FLUSH;
                            end
                        end else if (drain) begin
                            out_valid <= 1'b0;
                        end
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/xor_stream_ctrl.md
XOR_STREAM_CTRL -- requirements
Module: xor_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning byte width of data and key.
REQ-002 SHALL have parameter KEY_BYTES, default 4, meaning key schedule depth (power of two).
REQ-003 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port key_wr  input  1  write strobe for one key byte.
REQ-006 SHALL have port key_byte  input  DATA_W  key byte written at key_wr.
REQ-007 SHALL have port start  input  1  one-cycle request to process a message.
REQ-008 SHALL have port len  input  8  message length in bytes, sampled at start.
REQ-009 SHALL have port abort  input  1  cancel current message.
REQ-010 SHALL have port in_valid / in_data / in_ready  input / input DATA_W / output  upstream byte handshake.
REQ-011 SHALL have port out_valid / out_data / out_ready  output / output DATA_W / input  downstream byte handshake.
REQ-012 SHALL have port busy, done, key_ready, key_err  output  1 each  status flags.

Function
REQ-013 SHALL implement states IDLE, RUN, FLUSH; busy=1 in RUN and FLUSH only.
REQ-014 Key load SHALL occur only in IDLE: key_wr writes key_reg[wr_ptr], wr_ptr increments mod KEY_BYTES; key_wr in RUN/FLUSH is ignored.
REQ-015 key_wr with wr_ptr==0 SHALL clear key_ready; write at wr_ptr==KEY_BYTES-1 SHALL set key_ready next cycle.
REQ-016 start in IDLE with key_ready=1 and len!=0 SHALL latch len into remaining, clear idx, enter RUN next cycle.
REQ-017 start in IDLE with key_ready=1 and len==0 SHALL pulse done one cycle next cycle, remain IDLE.
REQ-018 start in IDLE with key_ready=0 SHALL pulse key_err one cycle next cycle, remain IDLE; start while busy SHALL be ignored.
REQ-019 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready); in_ready=0 in IDLE and FLUSH.
REQ-020 Accepted byte (in_valid && in_ready) SHALL register out_data = in_data XOR key_reg[idx], set out_valid, idx = idx+1 mod KEY_BYTES, remaining-1; latency one cycle.
REQ-021 out_valid SHALL clear on out_valid && out_ready with no simultaneous accept; out_data SHALL hold stable while out_valid && !out_ready.
REQ-022 Accept that drives remaining to 0 SHALL move RUN to FLUSH.
REQ-023 In FLUSH, completion of final output transfer (out_valid && out_ready) SHALL pulse done for that cycle's next cycle and return to IDLE.
REQ-024 done and key_err SHALL be single-cycle pulses, never asserted together.
REQ-025 abort in RUN or FLUSH SHALL return to IDLE next cycle, clear out_valid, suppress done; key_reg, key_ready retained; abort in IDLE ignored.
REQ-026 abort and start in the same cycle in IDLE SHALL be treated as start only.
REQ-027 Encrypt and decrypt SHALL be the same operation (XOR); identical key and stream yields original data on second pass.

Reset
REQ-028 rst SHALL force state IDLE, wr_ptr=0, idx=0, remaining=0, key_ready=0, out_valid=0, out_data=0, busy=0, done=0, key_err=0, in_ready=0.
REQ-029 rst SHALL take priority over all inputs, including mid-message; key_reg contents SHALL be zeroed.

Verification
REQ-030 Keys AA,33,0F,55; len=4; data FF,FF,F0,FF, out_ready=1 -> out 55,CC,FF,AA, done one cycle after last transfer.
REQ-031 Same keys, len=6, data 00 x6 -> out AA,33,0F,55,AA,33 (key wrap-around), idx=2 at end.
REQ-032 out_ready held 0 for 3 cycles after first output -> in_ready=0, out_data stable, no byte lost or duplicated.
REQ-033 start with key_ready=0 -> key_err pulse, busy=0; start with len=0 and key loaded -> done pulse, no out_valid.
REQ-034 abort after 2 of 4 bytes -> IDLE next cycle, out_valid=0, no done; new start replays from key_reg[0].
REQ-035 rst asserted mid-RUN -> all outputs reset values next cycle, key_ready=0; start then yields key_err.
